// File: rtl/logic_loom_pkg.sv
// logic_loom_pkg: state encoding and fixed pattern for the 1011 sequence detector
package logic_loom_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S10  = 3'd2,
        S101 = 3'd3,
        HIT  = 3'd4
    } state_e;
    localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/logic_loom.sv
// logic_loom: overlapping Moore detector for serial pattern 1011 with a one-cycle match flag
module logic_loom
    import logic_loom_pkg::*;
(
    input  logic n,
    input  logic clk,
    input  logic reset,
    output logic out
);
    state_e state_q, state_d;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = n ? S1   : IDLE;
            S1:      state_d = n ? S1   : S10;
            S10:     state_d = n ? S101 : IDLE;
            S101:    state_d = n ? HIT  : S10;
            HIT:     state_d = n ? S1   : S10;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end
    assign out = (state_q == HIT);
endmodule

// File: tb/tb_logic_loom.sv
// tb_logic_loom: directed-vector bench for the 1011 overlapping sequence detector
module tb_logic_loom;
    import logic_loom_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic n = 1'b0;
    logic out;
    int tests = 0;
    int fails = 0;
    logic_loom dut (.n(n), .clk(clk), .reset(reset), .out(out));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset = 1'b1;
            n = ~n;
            @(posedge clk);
            #1;
            check($sformatf("reset_out[%0d]", i), {3'b0, out}, 4'h0);
            check($sformatf("reset_state[%0d]", i), {1'b0, dut.state_q}, {1'b0, IDLE});
        end
    endtask
    // bits and exp are MSB-first: bit len-1 is driven first, exp is out after each edge
    task automatic run_seq(input string tag, input logic [15:0] bits, input logic [15:0] exp, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge clk);
            reset = 1'b0;
            n = bits[i];
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, len - 1 - i), {3'b0, out}, {3'b0, exp[i]});
        end
    endtask
    initial begin
        do_reset(2);
        run_seq("basic", {12'b0, PATTERN}, 16'b0001, 4);
        run_seq("basic_end", 16'b0, 16'b0, 1);
        do_reset(1);
        run_seq("overlap", 16'b1011011, 16'b0001001, 7);
        run_seq("overlap_end", 16'b0, 16'b0, 1);
        do_reset(1);
        run_seq("near_miss", 16'b100111010, 16'b000000000, 9);
        do_reset(1);
        run_seq("rep_ones", 16'b111011, 16'b000001, 6);
        do_reset(1);
        run_seq("mid_pre", 16'b101, 16'b000, 3);
        do_reset(1);
        run_seq("mid_post", 16'b11, 16'b00, 2);
        do_reset(1);
        run_seq("hit_pre", 16'b1011, 16'b0001, 4);
        do_reset(1);
        run_seq("hit_post", 16'b011, 16'b000, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
